led595_chain: RTL and testbench



---
 rtl/led595_pkg.sv | 12 +
 rtl/led595_tick.sv | 28 ++
 rtl/led595_chain.sv | 107 ++++++++++
 tb/tb_led595_chain.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led595_pkg.sv
// led595_pkg: shared types and constants for the 74HC595 chain driver.
package led595_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } led595_state_t;

  localparam int LED595_BITS_PER_CHIP = 8;

endpackage

// File: rtl/led595_tick.sv
// led595_tick: one-cycle strobe every DIV system cycles.
module led595_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led595_chain.sv
// led595_chain: shifts a parallel word into a 74HC595 daisy chain
// on a divided serial clock, then pulses the storage latch.
import led595_pkg::*;

module led595_chain #(
  parameter int N_CHIPS   = 2,
  parameter int DIV       = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [LED595_BITS_PER_CHIP*N_CHIPS-1:0] data,
  input  logic                                  valid,
  output logic                                  ready,
  output logic                                  led595_clk,
  output logic                                  led595_dout,
  output logic                                  led595_latch
);

  localparam int W  = LED595_BITS_PER_CHIP * N_CHIPS;
  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  led595_state_t r_state;
  logic [W-1:0]  r_sr;
  logic [BW-1:0] r_bit;
  logic          r_hi;
  logic [W-1:0]  w_load;
  logic          w_tick;
  logic          w_clr;

  always_comb begin
    w_load = data;
    if (LSB_FIRST) begin
      for (int i = 0; i < W; i++) begin
        w_load[i] = data[W-1-i];
      end
    end
  end

  // Holding the divider clear in IDLE aligns the first low phase to accept.
  assign w_clr       = (r_state == IDLE);
  assign led595_dout = r_sr[W-1];

  led595_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sr         <= '0;
      r_bit        <= '0;
      r_hi         <= 1'b0;
      ready        <= 1'b1;
      led595_clk   <= 1'b0;
      led595_latch <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (valid) begin
            r_sr    <= w_load;
            r_bit   <= '0;
            r_hi    <= 1'b0;
            ready   <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            if (!r_hi) begin
              r_hi       <= 1'b1;
              led595_clk <= 1'b1;
            end else begin
              r_hi       <= 1'b0;
              led595_clk <= 1'b0;
              r_sr       <= {r_sr[W-2:0], 1'b0};
              if (r_bit == LAST_BIT) begin
                r_bit        <= '0;
                led595_latch <= 1'b1;
                r_state      <= LATCH;
              end else begin
                r_bit <= r_bit + BW'(1);
              end
            end
          end
        end
        LATCH: begin
          if (w_tick) begin
            led595_latch <= 1'b0;
            ready        <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led595_chain.sv
// tb_led595_chain: two chain drivers (MSB/DIV=2, LSB/DIV=1) checked against
// a behavioural 595 chain model through per-instance scoreboards.
module tb_led595_chain;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int g, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL u%0d.%s act=%0h req=%0h", g, nm, act, req);
    end
  endtask

  // A chip chain fed data[0] first ends up holding the word mirrored.
  function automatic logic [W-1:0] mirror(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[W-1-i];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D    = (g == 0) ? 2 : 1;
    localparam bit L    = (g == 1);
    localparam int TLEN = 2 * D * W + D;

    logic         rst_n;
    logic         valid;
    logic [W-1:0] data;
    logic         ready;
    logic         sck;
    logic         dout;
    logic         lat;
    logic         done;

    logic [W-1:0] exq[$];
    int           accq[$];
    logic [W-1:0] chain;
    int           nrise;
    int           latlen;
    logic         p_sck, p_lat, p_rdy, hdout;

    led595_chain #(
      .N_CHIPS   (2),
      .DIV       (D),
      .LSB_FIRST (L)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data         (data),
      .valid        (valid),
      .ready        (ready),
      .led595_clk   (sck),
      .led595_dout  (dout),
      .led595_latch (lat)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        chain  = '0;
        nrise  = 0;
        latlen = 0;
        p_sck  = 1'b0;
        p_lat  = 1'b0;
        p_rdy  = 1'b1;
        hdout  = 1'b0;
      end else begin
        if (sck && !p_sck) begin
          chain = {chain[W-2:0], dout};
          hdout = dout;
          nrise++;
        end
        if (sck && p_sck) chk(g, "dout_hold", dout, hdout);
        if (sck || lat) chk(g, "ready_busy", ready, 0);
        if (lat && !p_lat) begin
          chk(g, "bits_per_word", nrise, W);
          nrise = 0;
          latlen = 0;
          chk(g, "latch_expected", exq.size() != 0, 1);
          if (exq.size() != 0) chk(g, "latched_word", chain, exq.pop_front());
        end
        if (lat) begin
          latlen++;
          chk(g, "sck_low_in_latch", sck, 0);
        end
        if (!lat && p_lat) chk(g, "latch_len", latlen, D);
        if (ready && !p_rdy) begin
          chk(g, "accept_known", accq.size() != 0, 1);
          if (accq.size() != 0) chk(g, "xfer_len", cyc - accq.pop_front(), TLEN);
        end
        p_sck = sck;
        p_lat = lat;
        p_rdy = ready;
      end
    end

    task automatic step(input logic v, input logic [W-1:0] d);
      valid = v;
      data  = d;
      if (v && ready) begin
        exq.push_back(L ? mirror(d) : d);
        accq.push_back(cyc + 1);
      end
      @(negedge clk);
    endtask

    task automatic noise();
      step(!ready && ($urandom_range(0, 1) == 1), W'($urandom));
    endtask

    task automatic send(input logic [W-1:0] d);
      int n = 0;
      while (!ready && n < 4000) begin
        noise();
        n++;
      end
      chk(g, "ready_wait", ready, 1);
      if (ready) step(1'b1, d);
    endtask

    task automatic idle_wait();
      int n = 0;
      while (!ready && n < 4000) begin
        noise();
        n++;
      end
      valid = 1'b0;
      chk(g, "idle_wait", ready, 1);
      repeat (2) @(negedge clk);
    endtask

    initial begin
      logic [W-1:0] d;
      logic         was;
      int           acc;
      int           n;
      done  = 1'b0;
      rst_n = 1'b0;
      valid = 1'b0;
      data  = '0;
      repeat (2) @(negedge clk);
      chk(g, "rst_ready", ready, 1);
      chk(g, "rst_sck", sck, 0);
      chk(g, "rst_dout", dout, 0);
      chk(g, "rst_latch", lat, 0);
      #2 rst_n = 1'b1;
      @(negedge clk);

      send(16'hA55A);
      send(16'h0040);
      repeat (4) send(W'($urandom));
      idle_wait();

      d   = W'($urandom);
      acc = 0;
      n   = 0;
      while (acc < 4 && n < 2000) begin
        was = ready;
        step(1'b1, d);
        if (was) begin
          acc++;
          d = W'($urandom);
          chk(g, "b2b_ready_1cyc", ready, 0);
        end
        n++;
      end
      chk(g, "b2b_count", acc, 4);
      idle_wait();

      send(W'($urandom));
      n = 0;
      while (nrise < 5 && n < 1000) begin
        noise();
        n++;
      end
      chk(g, "five_bits_out", nrise, 5);
      #2 rst_n = 1'b0;
      #1;
      chk(g, "midrst_ready", ready, 1);
      chk(g, "midrst_sck", sck, 0);
      chk(g, "midrst_dout", dout, 0);
      chk(g, "midrst_latch", lat, 0);
      exq.delete();
      accq.delete();
      valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      send(W'($urandom));
      send(16'hFFFF);
      idle_wait();
      repeat (3) @(negedge clk);
      chk(g, "queue_drained", exq.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(u[0].done === 1'b1 && u[1].done === 1'b1) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (!(u[0].done === 1'b1 && u[1].done === 1'b1)) begin
      total++;
      bad++;
      $display("FAIL run_timeout done0=%0b done1=%0b req=1",
               u[0].done, u[1].done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
